// File: rtl/mips_mem_pkg.sv
// Shared memory-path definitions: Trunk encodings (same as the control unit),
// sequencer state encodings and little-endian lane selects.
package mips_mem_pkg;

  localparam logic [1:0] TRUNK_WORD     = 2'b00;
  localparam logic [1:0] TRUNK_HALF     = 2'b01;
  localparam logic [1:0] TRUNK_BYTE     = 2'b10;
  localparam logic [1:0] TRUNK_WORD_ALT = 2'b11;

  localparam logic [1:0] LANE_B0 = 2'd0;
  localparam logic [1:0] LANE_B1 = 2'd1;
  localparam logic [1:0] LANE_B2 = 2'd2;
  localparam logic [1:0] LANE_B3 = 2'd3;

  localparam logic LANE_H_LO = 1'b0;
  localparam logic LANE_H_HI = 1'b1;

  typedef enum logic [2:0] {
    MAS_IDLE     = 3'd0,
    MAS_RD_ISSUE = 3'd1,
    MAS_RD_WAIT  = 3'd2,
    MAS_WR       = 3'd3,
    MAS_DONE     = 3'd4
  } mas_state_e;

  // The reserved Trunk code behaves as a full word access.
  function automatic logic trunk_is_word(input logic [1:0] trunk);
    return (trunk == TRUNK_WORD) || (trunk == TRUNK_WORD_ALT);
  endfunction

endpackage

// File: rtl/mas_lane_unit.sv
// Combinational byte-lane logic: load extract/extend from a RAM word and
// read-modify-write merge of SB/SH store data into the old word.
module mas_lane_unit
  import mips_mem_pkg::*;
(
  input  logic [1:0]  trunk,
  input  logic        is_signed,
  input  logic [1:0]  byte_off,
  input  logic [31:0] mem_word,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = 8'h00;
    case (byte_off)
      LANE_B0: sel_byte = mem_word[7:0];
      LANE_B1: sel_byte = mem_word[15:8];
      LANE_B2: sel_byte = mem_word[23:16];
      LANE_B3: sel_byte = mem_word[31:24];
      default: sel_byte = 8'h00;
    endcase
    sel_half = (byte_off[1] == LANE_H_HI) ? mem_word[31:16] : mem_word[15:0];
  end

  always_comb begin
    load_data = mem_word;
    case (trunk)
      TRUNK_BYTE: load_data = {{24{is_signed & sel_byte[7]}}, sel_byte};
      TRUNK_HALF: load_data = {{16{is_signed & sel_half[15]}}, sel_half};
      default:    load_data = mem_word;
    endcase
  end

  // Only the addressed lane is replaced; the other lanes keep the old RAM contents.
  always_comb begin
    merged_word = store_data;
    case (trunk)
      TRUNK_BYTE: begin
        merged_word = mem_word;
        case (byte_off)
          LANE_B0: merged_word[7:0]   = store_data[7:0];
          LANE_B1: merged_word[15:8]  = store_data[7:0];
          LANE_B2: merged_word[23:16] = store_data[7:0];
          LANE_B3: merged_word[31:24] = store_data[7:0];
          default: merged_word = mem_word;
        endcase
      end
      TRUNK_HALF: begin
        merged_word = mem_word;
        if (byte_off[1] == LANE_H_HI) merged_word[31:16] = store_data[15:0];
        else                          merged_word[15:0]  = store_data[15:0];
      end
      default: merged_word = store_data;
    endcase
  end

endmodule

// File: rtl/mem_access_sequencer.sv
// Multi-cycle MEM-stage sequencer for a word-wide data RAM (loads, stores, SB/SH RMW).
// Optional MAS_ALIGN_CHECK_EN rejects misaligned half/word accesses with Err.
module mem_access_sequencer
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              I_CLK,
  input  logic              I_RST_N,
  input  logic              I_MAS_MemRead,
  input  logic              I_MAS_MemWrite,
  input  logic [1:0]        I_MAS_Trunk,
  input  logic              I_MAS_signed,
  input  logic [ADDR_W-1:0] I_MAS_Addr,
  input  logic [DATA_W-1:0] I_MAS_WData,
  output logic [DATA_W-1:0] O_MAS_RData,
  output logic              O_MAS_Stall,
  output logic              O_MAS_Done,
  output logic              O_MAS_Err,
  output logic [ADDR_W-1:0] O_MAS_MemAddr,
  output logic              O_MAS_MemRE,
  output logic              O_MAS_MemWE,
  output logic [DATA_W-1:0] O_MAS_MemWData,
  input  logic [DATA_W-1:0] I_MAS_MemRData,
  input  logic              I_MAS_MemRValid
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  mas_state_e        state;
  logic [CNT_W-1:0]  wait_cnt;
  logic              req_store;
  logic              req_signed;
  logic [1:0]        req_trunk;
  logic [1:0]        req_off;
  logic [DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_re_q;
  logic              mem_we_q;
  logic              done_q;
  logic              err_q;
  logic              req_any;
  logic              misaligned;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merged_word;

  assign req_any = I_MAS_MemRead | I_MAS_MemWrite;

`ifdef MAS_ALIGN_CHECK_EN
  assign misaligned = ((I_MAS_Trunk == TRUNK_HALF) && I_MAS_Addr[0]) ||
                      (trunk_is_word(I_MAS_Trunk) && (I_MAS_Addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  mas_lane_unit u_lane (
    .trunk       (req_trunk),
    .is_signed   (req_signed),
    .byte_off    (req_off),
    .mem_word    (I_MAS_MemRData),
    .store_data  (req_wdata),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  // Stall must rise in the same cycle the request appears, so it cannot be registered.
  assign O_MAS_Stall = ((state != MAS_IDLE) && (state != MAS_DONE)) ||
                       ((state == MAS_IDLE) && req_any);

  assign O_MAS_RData    = rdata_q;
  assign O_MAS_Done     = done_q;
  assign O_MAS_Err      = err_q;
  assign O_MAS_MemAddr  = mem_addr_q;
  assign O_MAS_MemRE    = mem_re_q;
  assign O_MAS_MemWE    = mem_we_q;
  assign O_MAS_MemWData = mem_wdata_q;

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state       <= MAS_IDLE;
      wait_cnt    <= '0;
      req_store   <= 1'b0;
      req_signed  <= 1'b0;
      req_trunk   <= TRUNK_WORD;
      req_off     <= 2'b00;
      req_wdata   <= '0;
      rdata_q     <= '0;
      mem_wdata_q <= '0;
      mem_addr_q  <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      mem_re_q <= 1'b0;
      mem_we_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      case (state)
        MAS_IDLE: begin
          if (req_any) begin
            req_store  <= I_MAS_MemWrite;
            req_signed <= I_MAS_signed;
            req_trunk  <= I_MAS_Trunk;
            req_off    <= I_MAS_Addr[1:0];
            req_wdata  <= I_MAS_WData;
            mem_addr_q <= {I_MAS_Addr[ADDR_W-1:2], 2'b00};
            if (misaligned) begin
              rdata_q <= '0;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
              state   <= MAS_DONE;
            end else if (I_MAS_MemWrite && trunk_is_word(I_MAS_Trunk)) begin
              mem_wdata_q <= I_MAS_WData;
              mem_we_q    <= 1'b1;
              state       <= MAS_WR;
            end else begin
              mem_re_q <= 1'b1;
              state    <= MAS_RD_ISSUE;
            end
          end
        end
        MAS_RD_ISSUE: begin
          wait_cnt <= '0;
          state    <= MAS_RD_WAIT;
        end
        MAS_RD_WAIT: begin
          if (I_MAS_MemRValid) begin
            if (req_store) begin
              mem_wdata_q <= merged_word;
              mem_we_q    <= 1'b1;
              state       <= MAS_WR;
            end else begin
              rdata_q <= load_data;
              done_q  <= 1'b1;
              state   <= MAS_DONE;
            end
          end else if ((TIMEOUT != 0) && (wait_cnt == TO_LAST)) begin
            // Give up rather than hang the pipeline; no write follows a failed read.
            rdata_q <= '0;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            state   <= MAS_DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        MAS_WR: begin
          rdata_q <= '0;
          done_q  <= 1'b1;
          state   <= MAS_DONE;
        end
        MAS_DONE: state <= MAS_IDLE;
        default:  state <= MAS_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Self-checking bench for mem_access_sequencer: directed cases plus randomized
// accesses against a word-array RAM model (MAS_ALIGN_CHECK_EN cases when defined).
module tb_mem_access_sequencer;
  import mips_mem_pkg::*;

  localparam int TIMEOUT = 15;

  logic        clk;
  logic        rst_n;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  trunk;
  logic        is_signed;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        done;
  logic        err;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;

  logic [31:0] ram_dut   [16];
  logic [31:0] model_ram [16];

  int tests_run;
  int tests_failed;

  mem_access_sequencer #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .I_CLK           (clk),
    .I_RST_N         (rst_n),
    .I_MAS_MemRead   (mem_read),
    .I_MAS_MemWrite  (mem_write),
    .I_MAS_Trunk     (trunk),
    .I_MAS_signed    (is_signed),
    .I_MAS_Addr      (addr),
    .I_MAS_WData     (wdata),
    .O_MAS_RData     (rdata),
    .O_MAS_Stall     (stall),
    .O_MAS_Done      (done),
    .O_MAS_Err       (err),
    .O_MAS_MemAddr   (mem_addr),
    .O_MAS_MemRE     (mem_re),
    .O_MAS_MemWE     (mem_we),
    .O_MAS_MemWData  (mem_wdata),
    .I_MAS_MemRData  (mem_rdata),
    .I_MAS_MemRValid (mem_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_word(input int idx, input logic [31:0] val);
    ram_dut[idx]   = val;
    model_ram[idx] = val;
  endtask

  // lat = cycles from the RE strobe to RValid; 0 means the RAM never answers.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [1:0] trk,
                               input logic sgn, input logic [31:0] a, input logic [31:0] wd,
                               input int lat);
    logic        is_store, is_word, misalign, timed_out, seen_done, stall_ok, got_err;
    int          idx, sh, re_cnt, we_cnt, done_cyc, valid_cyc, exp_done;
    logic [31:0] old_word, exp_rdata, exp_wdata, got_rdata, got_wdata, re_addr, we_addr;

    is_store  = wr;
    is_word   = (trk == TRUNK_WORD) || (trk == TRUNK_WORD_ALT);
    idx       = int'(a[5:2]);
    old_word  = model_ram[idx];
    misalign  = 1'b0;
`ifdef MAS_ALIGN_CHECK_EN
    misalign  = ((trk == TRUNK_HALF) && a[0]) || (is_word && (a[1:0] != 2'b00));
`endif
    timed_out = !misalign && !(is_store && is_word) && (lat == 0);
    exp_rdata = 32'h0;
    exp_wdata = 32'h0;
    if (!misalign && !timed_out) begin
      if (is_store) begin
        if (is_word) exp_wdata = wd;
        else if (trk == TRUNK_BYTE) begin
          sh = 8 * int'(a[1:0]);
          exp_wdata = (old_word & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
        end else begin
          sh = 16 * int'(a[1]);
          exp_wdata = (old_word & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
        end
        model_ram[idx] = exp_wdata;
      end else begin
        if (is_word) exp_rdata = old_word;
        else if (trk == TRUNK_BYTE) begin
          sh = 8 * int'(a[1:0]);
          exp_rdata = (old_word >> sh) & 32'hFF;
          if (sgn && exp_rdata[7]) exp_rdata = exp_rdata | 32'hFFFF_FF00;
        end else begin
          sh = 16 * int'(a[1]);
          exp_rdata = (old_word >> sh) & 32'hFFFF;
          if (sgn && exp_rdata[15]) exp_rdata = exp_rdata | 32'hFFFF_0000;
        end
      end
    end
    if (misalign)                exp_done = 1;
    else if (is_store && is_word) exp_done = 2;
    else if (timed_out)          exp_done = TIMEOUT + 2;
    else if (is_store)           exp_done = lat + 3;
    else                         exp_done = lat + 2;

    mem_read  = rd;
    mem_write = wr;
    trunk     = trk;
    is_signed = sgn;
    addr      = a;
    wdata     = wd;
    #1;
    checkOutput("stall_on_request", 32'(stall), 32'd1);

    re_cnt = 0; we_cnt = 0; valid_cyc = -1; done_cyc = -1;
    seen_done = 1'b0; stall_ok = 1'b1; got_err = 1'b0;
    got_rdata = 32'h0; got_wdata = 32'h0; re_addr = 32'h0; we_addr = 32'h0;
    for (int cyc = 1; cyc <= 40 && !seen_done; cyc++) begin
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      if (mem_re) begin
        re_cnt++;
        re_addr = mem_addr;
        if (lat > 0) valid_cyc = cyc + lat;
      end
      if (cyc == valid_cyc) begin
        mem_rvalid = 1'b1;
        mem_rdata  = ram_dut[re_addr[5:2]];
      end
      if (mem_we) begin
        we_cnt++;
        we_addr = mem_addr;
        got_wdata = mem_wdata;
        ram_dut[mem_addr[5:2]] = mem_wdata;
      end
      if (done) begin
        seen_done = 1'b1;
        done_cyc  = cyc;
        got_rdata = rdata;
        got_err   = err;
        if (stall) stall_ok = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_rvalid = 1'b0;
      end else if (!stall) begin
        stall_ok = 1'b0;
      end
    end

    checkOutput("done_seen", 32'(seen_done), 32'd1);
    checkOutput("done_cycle", 32'(done_cyc), 32'(exp_done));
    checkOutput("err", 32'(got_err), 32'(misalign || timed_out));
    if (!is_store || misalign || timed_out) checkOutput("rdata", got_rdata, exp_rdata);
    checkOutput("re_count", 32'(re_cnt), (misalign || (is_store && is_word)) ? 32'd0 : 32'd1);
    checkOutput("we_count", 32'(we_cnt), (is_store && !misalign && !timed_out) ? 32'd1 : 32'd0);
    if (re_cnt == 1) checkOutput("re_addr", re_addr, a & 32'hFFFF_FFFC);
    if (we_cnt == 1) begin
      checkOutput("we_addr", we_addr, a & 32'hFFFF_FFFC);
      checkOutput("we_data", got_wdata, exp_wdata);
    end
    checkOutput("stall_profile", 32'(stall_ok), 32'd1);

    @(posedge clk); #1;
    checkOutput("idle_after", {27'h0, done, mem_we, mem_re, err, stall}, 32'h0);
  endtask

  initial begin
    int we_seen, act_seen;
    tests_run = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; trunk = TRUNK_WORD; is_signed = 1'b0;
    addr = 32'h0; wdata = 32'h0; mem_rdata = 32'h0; mem_rvalid = 1'b0;
    for (int i = 0; i < 16; i++) set_word(i, $urandom);

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_outputs", {27'h0, done, mem_we, mem_re, err, stall}, 32'h0);
    checkOutput("reset_buses", mem_addr | mem_wdata | rdata, 32'h0);
    rst_n = 1'b1;

    $display("[TB] directed cases");
    set_word(4, 32'hDEAD_BEEF);
    applyStimulus(1'b1, 1'b0, TRUNK_WORD, 1'b0, 32'h10, 32'h0, 1);
    set_word(4, 32'h80FF_0102);
    applyStimulus(1'b1, 1'b0, TRUNK_BYTE, 1'b1, 32'h13, 32'h0, 1);
    applyStimulus(1'b1, 1'b0, TRUNK_BYTE, 1'b0, 32'h13, 32'h0, 2);
    set_word(8, 32'h1122_3344);
    applyStimulus(1'b0, 1'b1, TRUNK_HALF, 1'b0, 32'h22, 32'h0000_ABCD, 1);
    checkOutput("sh_ram_word", ram_dut[8], 32'hABCD_3344);
    applyStimulus(1'b1, 1'b0, TRUNK_WORD, 1'b0, 32'h30, 32'h0, 0);
    applyStimulus(1'b0, 1'b1, TRUNK_BYTE, 1'b0, 32'h31, 32'h55, 0);
    applyStimulus(1'b1, 1'b1, TRUNK_WORD_ALT, 1'b0, 32'h3C, 32'hCAFE_F00D, 3);
    applyStimulus(1'b1, 1'b0, TRUNK_HALF, 1'b1, 32'h3E, 32'h0, 12);
`ifdef MAS_ALIGN_CHECK_EN
    applyStimulus(1'b1, 1'b0, TRUNK_WORD, 1'b0, 32'h05, 32'h0, 1);
    applyStimulus(1'b0, 1'b1, TRUNK_HALF, 1'b0, 32'h07, 32'h1234, 1);
`endif

    $display("[TB] reset during SB read phase");
    set_word(2, 32'h5566_7788);
    mem_read = 1'b0; mem_write = 1'b1; trunk = TRUNK_BYTE; addr = 32'h09; wdata = 32'hAA;
    @(posedge clk); #1;
    checkOutput("rst_case_re", 32'(mem_re), 32'd1);
    @(posedge clk); #1;
    #2;
    rst_n = 1'b0;
    mem_write = 1'b0;
    #1;
    checkOutput("rst_async_outputs", {27'h0, done, mem_we, mem_re, err, stall}, 32'h0);
    checkOutput("rst_async_buses", mem_addr | mem_wdata | rdata, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    we_seen = 0; act_seen = 0;
    for (int c = 0; c < 20; c++) begin
      mem_rvalid = (c == 2);
      mem_rdata  = ram_dut[2];
      @(posedge clk); #1;
      if (mem_we) we_seen++;
      if (mem_re || done || err || stall) act_seen++;
    end
    mem_rvalid = 1'b0;
    checkOutput("rst_no_we", 32'(we_seen), 32'd0);
    checkOutput("rst_stays_idle", 32'(act_seen), 32'd0);
    checkOutput("rst_ram_kept", ram_dut[2], 32'h5566_7788);

    $display("[TB] randomized accesses");
    for (int n = 0; n < 60; n++) begin
      int sel, lat;
      logic r, w;
      sel = $urandom_range(0, 2);
      r = (sel != 1);
      w = (sel != 0);
      lat = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12);
      applyStimulus(r, w, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    $urandom & 32'h0000_03FF, $urandom, lat);
    end

    for (int i = 0; i < 16; i++)
      checkOutput($sformatf("ram_word_%0d", i), ram_dut[i], model_ram[i]);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
